// File: rtl/snake_body.sv
// Snake movement stage: steps the head one cell per move tick, shifts the body, flags wall/self collisions.
// Latency: head/length/move_tick change on the step edge; occupancy query answers one cycle after scan.
// Backpressure: none; buttons are levels sampled every cycle, eat is latched until the next step consumes it.
module snake_body #(
    parameter int TICK_DIV = 5_000_000,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3
) (
    input  logic       clk_50MHz,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       eat,
    input  logic [5:0] scan_x,
    input  logic [5:0] scan_y,
    output logic [5:0] head_x,
    output logic [5:0] head_y,
    output logic [4:0] length,
    output logic       dead,
    output logic       move_tick,
    output logic       body_hit,
    output logic       head_hit
);

    localparam int               CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [4:0]       LEN_MAX   = 5'(MAX_LEN);
    localparam logic [4:0]       LEN_INIT  = 5'(INIT_LEN);
    localparam logic [5:0]       HOME_X    = 6'd20;
    localparam logic [5:0]       HOME_Y    = 6'd15;
    localparam logic [5:0]       X_WALL_HI = 6'd39;
    localparam logic [5:0]       Y_WALL_HI = 6'd29;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        DEAD
    } state_t;

    // Opposite directions differ only in bit 0, which the reversal filter relies on.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef struct packed {
        logic [5:0] x;
        logic [5:0] y;
    } cell_t;

    state_t           state;
    state_t           state_nxt;
    dir_t             dir;
    dir_t             req_dir;
    dir_t             btn_dir;
    dir_t             dir_ref;
    cell_t            seg [MAX_LEN];
    cell_t            new_head;
    cell_t            scan_cell;
    logic [CNT_W-1:0] tick_cnt;
    logic             grow_pending;
    logic             go_idle;
    logic             tick_wrap;
    logic             step_go;
    logic             step_die;
    logic             grows;
    logic             wall_hit;
    logic             self_hit;
    logic [4:0]       self_lim;
    logic             btn_any;
    logic             req_take;
    logic             body_match;

    assign go_idle   = rst || (mode != 2'd1);
    assign tick_wrap = (tick_cnt == CNT_LAST);
    assign head_x    = seg[0].x;
    assign head_y    = seg[0].y;
    assign scan_cell = '{x: scan_x, y: scan_y};

    // An eat on the step cycle itself counts; at full length the pending growth is simply dropped.
    assign grows = (grow_pending || eat) && (length < LEN_MAX);

    // State register.
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and step/death strobes; a step that would collide becomes a death instead.
    always_comb begin
        state_nxt = state;
        step_go   = 1'b0;
        step_die  = 1'b0;
        if (go_idle) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = PLAY;
                PLAY: begin
                    if (tick_wrap) begin
                        if (wall_hit || self_hit) begin
                            state_nxt = DEAD;
                            step_die  = 1'b1;
                        end else begin
                            step_go = 1'b1;
                        end
                    end
                end
                DEAD:    state_nxt = DEAD;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Button priority and reversal filter; on a step cycle compare against the direction being committed.
    always_comb begin
        btn_any = 1'b1;
        btn_dir = DIR_RIGHT;
        if (btn_up) begin
            btn_dir = DIR_UP;
        end else if (btn_down) begin
            btn_dir = DIR_DOWN;
        end else if (btn_left) begin
            btn_dir = DIR_LEFT;
        end else if (btn_right) begin
            btn_dir = DIR_RIGHT;
        end else begin
            btn_any = 1'b0;
        end
        dir_ref  = tick_wrap ? req_dir : dir;
        req_take = btn_any && ((btn_dir ^ dir_ref) != 2'b01);
    end

    // Candidate head cell for the next step and wall test.
    always_comb begin
        new_head = seg[0];
        case (req_dir)
            DIR_UP:    new_head.y = seg[0].y - 6'd1;
            DIR_DOWN:  new_head.y = seg[0].y + 6'd1;
            DIR_LEFT:  new_head.x = seg[0].x - 6'd1;
            DIR_RIGHT: new_head.x = seg[0].x + 6'd1;
            default:   new_head   = seg[0];
        endcase
        wall_hit = (new_head.x == 6'd0) || (new_head.x == X_WALL_HI) ||
                   (new_head.y == 6'd0) || (new_head.y == Y_WALL_HI);
    end

    // Self collision: the tail vacates its cell on a plain step, but stays put when the body grows.
    always_comb begin
        self_hit = 1'b0;
        self_lim = grows ? length : length - 5'd1;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((5'(i) < self_lim) && (seg[i] == new_head)) begin
                self_hit = 1'b1;
            end
        end
    end

    // Renderer occupancy test against non-head segments.
    always_comb begin
        body_match = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((5'(i) < length) && (seg[i] == scan_cell)) begin
                body_match = 1'b1;
            end
        end
    end

    // Body, direction, growth and tick counter; IDLE keeps everything at the start position.
    always_ff @(posedge clk_50MHz) begin
        if (go_idle || (state == IDLE)) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg[i].x <= HOME_X - 6'(i);
                seg[i].y <= HOME_Y;
            end
            length       <= LEN_INIT;
            dir          <= DIR_RIGHT;
            req_dir      <= DIR_RIGHT;
            grow_pending <= 1'b0;
            tick_cnt     <= '0;
            dead         <= 1'b0;
            move_tick    <= 1'b0;
        end else if (state == PLAY) begin
            move_tick <= step_go;
            tick_cnt  <= tick_wrap ? '0 : tick_cnt + 1'b1;
            if (req_take) begin
                req_dir <= btn_dir;
            end
            if (step_go) begin
                for (int i = MAX_LEN - 1; i > 0; i--) begin
                    seg[i] <= seg[i-1];
                end
                seg[0]       <= new_head;
                dir          <= req_dir;
                grow_pending <= 1'b0;
                if (grows) begin
                    length <= length + 5'd1;
                end
            end else if (eat && !step_die) begin
                grow_pending <= 1'b1;
            end
            if (step_die) begin
                dead <= 1'b1;
            end
        end else begin
            move_tick <= 1'b0;
        end
    end

    // Registered query answers, live in every state.
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            body_hit <= 1'b0;
            head_hit <= 1'b0;
        end else begin
            body_hit <= body_match;
            head_hit <= (seg[0] == scan_cell);
        end
    end

endmodule

// File: tb/tb_snake_body.sv
// Bench for snake_body: directed query/step tables plus hand sequences for wall death, idle and reset.
// Latency: expectations sampled 1 time unit after each rising edge.
// Backpressure: not applicable; all stimulus is cycle-exact.
module tb_snake_body;

    localparam int U = 8;
    localparam int D = 4;
    localparam int L = 2;
    localparam int R = 1;

    typedef struct {
        int sx;
        int sy;
        int body;
        int head;
    } q_t;

    typedef struct {
        int btn1;
        int btn2;
        int eat0;
        int eat3;
        int qchk;
        int sx;
        int sy;
        int qbody;
        int ahx;
        int ahy;
        int alen;
        int adead;
        int amt;
        int bhx;
        int bhy;
        int blen;
    } win_t;

    logic       clk_50MHz = 1'b0;
    logic       rst       = 1'b1;
    logic [1:0] mode      = 2'd0;
    logic       btn_up    = 1'b0;
    logic       btn_down  = 1'b0;
    logic       btn_left  = 1'b0;
    logic       btn_right = 1'b0;
    logic       eat       = 1'b0;
    logic [5:0] scan_x    = 6'd20;
    logic [5:0] scan_y    = 6'd15;

    logic [5:0] a_head_x, a_head_y, b_head_x, b_head_y;
    logic [4:0] a_length, b_length;
    logic       a_dead, a_move_tick, a_body_hit, a_head_hit;
    logic       b_dead, b_move_tick, b_body_hit, b_head_hit;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_50MHz = ~clk_50MHz;

    snake_body #(.TICK_DIV(4), .MAX_LEN(16), .INIT_LEN(3)) dut_a (
        .clk_50MHz(clk_50MHz), .rst(rst), .mode(mode),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .eat(eat), .scan_x(scan_x), .scan_y(scan_y),
        .head_x(a_head_x), .head_y(a_head_y), .length(a_length), .dead(a_dead),
        .move_tick(a_move_tick), .body_hit(a_body_hit), .head_hit(a_head_hit)
    );

    snake_body #(.TICK_DIV(4), .MAX_LEN(4), .INIT_LEN(3)) dut_b (
        .clk_50MHz(clk_50MHz), .rst(rst), .mode(mode),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .eat(eat), .scan_x(scan_x), .scan_y(scan_y),
        .head_x(b_head_x), .head_y(b_head_y), .length(b_length), .dead(b_dead),
        .move_tick(b_move_tick), .body_hit(b_body_hit), .head_hit(b_head_hit)
    );

    task automatic tick();
        @(posedge clk_50MHz);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_btn(input int b);
        logic [3:0] v;
        v         = 4'(b);
        btn_up    = v[3];
        btn_down  = v[2];
        btn_left  = v[1];
        btn_right = v[0];
    endtask

    initial begin
        q_t   qtab [6];
        win_t wtab [13];

        // Queries against the start body (20,15),(19,15),(18,15).
        qtab[0] = '{19, 15, 1, 0};
        qtab[1] = '{20, 15, 0, 1};
        qtab[2] = '{5, 5, 0, 0};
        qtab[3] = '{18, 15, 1, 0};
        qtab[4] = '{17, 15, 0, 0};
        qtab[5] = '{21, 15, 0, 0};

        // One row per move window: dut_a has MAX_LEN 16, dut_b has MAX_LEN 4.
        //          btn1 btn2 e0 e3 qc sx  sy  qb  ahx ahy al ad amt bhx bhy bl
        wtab[0]  = '{0, 0, 0, 0, 0, 0,  0,  0, 21, 15, 3, 0, 1, 21, 15, 3};
        wtab[1]  = '{0, 0, 0, 0, 0, 0,  0,  0, 22, 15, 3, 0, 1, 22, 15, 3};
        wtab[2]  = '{L, 0, 0, 0, 0, 0,  0,  0, 23, 15, 3, 0, 1, 23, 15, 3};
        wtab[3]  = '{U, L, 0, 0, 0, 0,  0,  0, 23, 14, 3, 0, 1, 23, 14, 3};
        wtab[4]  = '{R, 0, 0, 0, 0, 0,  0,  0, 24, 14, 3, 0, 1, 24, 14, 3};
        wtab[5]  = '{0, 0, 1, 0, 1, 22, 15, 0, 25, 14, 4, 0, 1, 25, 14, 4};
        wtab[6]  = '{0, 0, 0, 0, 1, 23, 15, 1, 26, 14, 4, 0, 1, 26, 14, 4};
        wtab[7]  = '{0, 0, 0, 1, 0, 0,  0,  0, 27, 14, 5, 0, 1, 27, 14, 4};
        wtab[8]  = '{0, 0, 0, 0, 0, 0,  0,  0, 28, 14, 5, 0, 1, 28, 14, 4};
        wtab[9]  = '{U, 0, 0, 0, 0, 0,  0,  0, 28, 13, 5, 0, 1, 28, 13, 4};
        wtab[10] = '{L, 0, 0, 0, 0, 0,  0,  0, 27, 13, 5, 0, 1, 27, 13, 4};
        wtab[11] = '{D, 0, 0, 0, 0, 0,  0,  0, 27, 13, 5, 1, 0, 27, 14, 4};
        wtab[12] = '{0, 0, 1, 0, 0, 0,  0,  0, 27, 13, 5, 1, 0, 27, 15, 4};

        // Reset values; scan sits on the head so an unreset head_hit would show.
        tick();
        tick();
        chk("reset head_x", int'(a_head_x), 20);
        chk("reset head_y", int'(a_head_y), 15);
        chk("reset length", int'(a_length), 3);
        chk("reset dead", int'(a_dead), 0);
        chk("reset move_tick", int'(a_move_tick), 0);
        chk("reset body_hit", int'(a_body_hit), 0);
        chk("reset head_hit", int'(a_head_hit), 0);

        // Occupancy queries while idle.
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            scan_x = 6'(qtab[i].sx);
            scan_y = 6'(qtab[i].sy);
            tick();
            chk($sformatf("q%0d body_hit", i), int'(a_body_hit), qtab[i].body);
            chk($sformatf("q%0d head_hit", i), int'(a_head_hit), qtab[i].head);
            chk($sformatf("q%0d b body_hit", i), int'(b_body_hit), qtab[i].body);
        end

        // Enter PLAY; the first step lands four edges later.
        mode = 2'd1;
        tick();
        chk("enter head_x", int'(a_head_x), 20);
        for (int i = 0; i < 13; i++) begin
            set_btn(wtab[i].btn1);
            eat    = (wtab[i].eat0 != 0);
            scan_x = 6'(wtab[i].sx);
            scan_y = 6'(wtab[i].sy);
            tick();
            chk($sformatf("w%0d mid move_tick", i + 1), int'(a_move_tick), 0);
            if (wtab[i].qchk != 0) begin
                chk($sformatf("w%0d body_hit", i + 1), int'(a_body_hit), wtab[i].qbody);
            end
            set_btn(wtab[i].btn2);
            eat = 1'b0;
            tick();
            set_btn(0);
            tick();
            eat = (wtab[i].eat3 != 0);
            tick();
            eat = 1'b0;
            chk($sformatf("w%0d head_x", i + 1), int'(a_head_x), wtab[i].ahx);
            chk($sformatf("w%0d head_y", i + 1), int'(a_head_y), wtab[i].ahy);
            chk($sformatf("w%0d length", i + 1), int'(a_length), wtab[i].alen);
            chk($sformatf("w%0d dead", i + 1), int'(a_dead), wtab[i].adead);
            chk($sformatf("w%0d move_tick", i + 1), int'(a_move_tick), wtab[i].amt);
            chk($sformatf("w%0d b head_x", i + 1), int'(b_head_x), wtab[i].bhx);
            chk($sformatf("w%0d b head_y", i + 1), int'(b_head_y), wtab[i].bhy);
            chk($sformatf("w%0d b length", i + 1), int'(b_length), wtab[i].blen);
        end

        // Leaving play restores the start position.
        mode = 2'd0;
        tick();
        chk("idle head_x", int'(a_head_x), 20);
        chk("idle head_y", int'(a_head_y), 15);
        chk("idle length", int'(a_length), 3);
        chk("idle dead", int'(a_dead), 0);

        // Straight run into the right wall.
        mode = 2'd1;
        tick();
        for (int k = 1; k <= 18; k++) begin
            tick();
            tick();
            tick();
            chk($sformatf("run%0d pre move_tick", k), int'(a_move_tick), 0);
            tick();
            chk($sformatf("run%0d head_x", k), int'(a_head_x), 20 + k);
            chk($sformatf("run%0d move_tick", k), int'(a_move_tick), 1);
        end
        repeat (4) tick();
        chk("wall dead", int'(a_dead), 1);
        chk("wall head_x", int'(a_head_x), 38);
        chk("wall head_y", int'(a_head_y), 15);
        chk("wall move_tick", int'(a_move_tick), 0);
        chk("wall b dead", int'(b_dead), 1);
        repeat (4) tick();
        chk("wall frozen head_x", int'(a_head_x), 38);
        chk("wall frozen dead", int'(a_dead), 1);
        mode = 2'd0;
        tick();
        chk("wall idle head_x", int'(a_head_x), 20);
        chk("wall idle dead", int'(a_dead), 0);

        // An eat while idle must not carry into play.
        eat = 1'b1;
        tick();
        eat  = 1'b0;
        mode = 2'd1;
        tick();
        repeat (4) tick();
        chk("idle-eat head_x", int'(a_head_x), 21);
        chk("idle-eat length", int'(a_length), 3);

        // Reset landing on a step edge wins over the step.
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rst-step head_x", int'(a_head_x), 20);
        chk("rst-step move_tick", int'(a_move_tick), 0);
        chk("rst-step length", int'(a_length), 3);
        rst  = 1'b0;
        mode = 2'd0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/snake_body.md
# snake_body

Snake movement and body-tracking stage for the 40×30-cell playfield. Steps the snake one cell per move tick in the player-selected direction. Publishes `head_x`/`head_y` to the apple/eating stage and consumes its one-cycle `eat` pulse to grow the body. Detects wall and self collisions, and answers per-cell occupancy queries from the VGA renderer.

## Interface
- `TICK_DIV`, 5_000_000: clk cycles per move step (10 steps/s at 50 MHz).
- `MAX_LEN`, 16: body segment capacity, max 31.
- `INIT_LEN`, 3: length after reset/idle, 2..MAX_LEN.
- `clk_50MHz`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mode`  in  2  game mode; 1 = play, any other value = idle.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  debounced direction levels.
- `eat`  in  1  one-cycle pulse from the apple stage: head is on the apple.
- `scan_x`, `scan_y`  in  6 each  cell queried by the renderer.
- `head_x`, `head_y`  out  6 each  current head cell.
- `length`  out  5  current segment count.
- `dead`  out  1  collision occurred; snake frozen.
- `move_tick`  out  1  one-cycle pulse on every executed step.
- `body_hit`  out  1  queried cell holds a non-head segment.
- `head_hit`  out  1  queried cell is the head.

## Operation
- Storage: segment arrays `seg_x[0..MAX_LEN-1]` and `seg_y[0..MAX_LEN-1]`; segment 0 is the head. Only indices below `length` are valid.
- Direction encoding: `dir` is 2 bits; 0 = up (y−1), 1 = down (y+1), 2 = left (x−1), 3 = right (x+1).
- States: `IDLE`, `PLAY`, `DEAD`.
- `rst` or `mode`≠1, from any state → `IDLE` on the next edge. `IDLE` loads:
  - head (20,15), segment i at (20−i,15);
  - `length` = INIT_LEN, `dir` = right, `req_dir` = right;
  - grow_pending = 0, tick counter = 0, `dead` = 0.
- `IDLE` → `PLAY` when `mode`==1 and `rst`=0.
- `PLAY` direction request, sampled every cycle:
  - Priority up > down > left > right; `req_dir` ← the highest-priority pressed button.
  - A request that reverses the committed `dir` is ignored.
  - `dir` ← `req_dir` only at a step, so two presses inside one tick cannot fold the snake back onto itself.
- `PLAY` growth: an `eat` pulse sets grow_pending, which holds until consumed at the next step.
- `PLAY` tick counter: counts 0..TICK_DIV−1. At the wrap a step executes:
  1. Compute new head (nx,ny) from the new `dir`.
  2. Wall hit if nx∈{0,39} or ny∈{0,29}.
  3. Self hit if (nx,ny) equals seg[i] for i < `length`−1. Use i < `length` when growth will occur, because the tail does not vacate.
  4. On any hit: → `DEAD`, `dead`=1, no segment moves, `move_tick` stays 0.
  5. Otherwise: seg[i] ← seg[i−1] for i≥1, seg[0] ← (nx,ny), `move_tick`=1.
  6. If grow_pending: `length`+1 (saturating at MAX_LEN; grow_pending still clears at MAX_LEN).
- `DEAD`: all state frozen, `dead` held at 1. Leave only via `rst` or `mode`≠1.
- Query: `body_hit` = OR over 1≤i<`length` of seg[i]==(`scan_x`,`scan_y`); `head_hit` = seg[0] match. Both are registered and active in every state.

## Timing
- Reset values: `head_x`=20, `head_y`=15, `length`=INIT_LEN, `dead`=0, `move_tick`=0, `body_hit`=0, `head_hit`=0.
- The first step occurs TICK_DIV cycles after entering `PLAY`; steps then repeat every TICK_DIV cycles.
- `head_x`/`head_y`, `length` and `move_tick` all update on the same edge as the step.
- `eat` arriving on the same cycle as a step counts for that step.
- An `eat` during `DEAD` or `IDLE` is discarded.
- Query latency is exactly 1 cycle: scan at edge n → `body_hit`/`head_hit` valid after edge n+1.
- `rst` asserted mid-step takes precedence; no partial shift is ever visible.

## Test plan
- Reset, `mode`=1, TICK_DIV=4, no buttons → head (21,15) at cycle 4, (22,15) at cycle 8; `move_tick` high one cycle each step; `length`=3.
- Moving right, pulse `btn_left` → ignored, head keeps x+1. Then `btn_up` then `btn_left` inside one tick → only up is committed at the next step, head (x,14).
- `eat` pulse between steps → `length` 3→4 at the next step; the old tail cell remains occupied (`body_hit`=1 at the old tail position one cycle after querying it).
- Run right from (20,15) → after 18 steps head is (38,15); the 19th step sets `dead`=1, head stays (38,15), `move_tick` stays 0. `mode`=0 → head (20,15), `dead`=0.
- `length`=5; sequence up, left, down → self hit, `dead`=1. Repeat with MAX_LEN=4 and 3 eats → `length` saturates at 4.
- Query (19,15) after reset → `body_hit`=1 one cycle later; query (20,15) → `head_hit`=1, `body_hit`=0; query (5,5) → both 0.
